// File: rtl/ifetch_pipe.sv
// Instruction fetch front end: issues one imem read per cycle under a queue credit
// limit and buffers {pc, instr} pairs in a small FIFO for decode; redirects flush everything.
module ifetch_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 9,
    parameter int          FQ_DEPTH = 4,
    parameter int          CW       = $clog2(FQ_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_instr,
    output logic [CW-1:0]      fq_count
);

    localparam int PW = $clog2(FQ_DEPTH);

    logic [31:0]   fetch_pc_reg;
    logic [31:0]   req_pc_reg;
    logic          inflight_reg;
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;

    logic issue;
    logic push;
    logic pop;

    logic [63:0] entry_data [FQ_DEPTH];

    // The in-flight request holds a credit, so a queue that is full counting
    // outstanding reads never receives a push it cannot store.
    assign issue = !reset && !redirect_valid
                   && ((count_reg + CW'(inflight_reg)) < CW'(FQ_DEPTH));
    assign push  = !reset && inflight_reg && !redirect_valid;
    assign pop   = (count_reg != '0) && out_ready;

    assign imem_en   = issue;
    assign imem_addr = fetch_pc_reg[IMEM_AW+1:2];
    assign out_valid = (count_reg != '0);
    assign fq_count  = count_reg;
    assign out_pc    = out_valid ? entry_data[head_reg][63:32] : 32'h0;
    assign out_instr = out_valid ? entry_data[head_reg][31:0]  : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= 32'h0;
            inflight_reg <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
            inflight_reg <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                req_pc_reg   <= fetch_pc_reg;
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Queue storage is left unreset; out_pc/out_instr are masked while empty.
    generate
        for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
            logic [63:0] data_reg;
            always_ff @(posedge clk) begin
                if (push && (tail_reg == PW'(gi))) begin
                    data_reg <= {req_pc_reg, imem_rdata};
                end
            end
            assign entry_data[gi] = data_reg;
        end
    endgenerate

    overflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_reg == CW'(FQ_DEPTH))));

endmodule

// File: tb/tb_ifetch_pipe.sv
// Directed bench for ifetch_pipe: reset release, backpressure, redirects, PC wrap
// and mid-run reset, against hand-computed expectations.
module tb_ifetch_pipe;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = 32'h0;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [2:0]    fq_count;

    logic          redirect_valid_b = 1'b0;
    logic [31:0]   redirect_pc_b    = 32'h0;
    logic          out_ready_b      = 1'b1;
    logic          imem_en_b;
    logic [AW-1:0] imem_addr_b;
    logic [31:0]   imem_rdata_b = 32'h0;
    logic          out_valid_b;
    logic [31:0]   out_pc_b;
    logic [31:0]   out_instr_b;
    logic [2:0]    fq_count_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifetch_pipe dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .fq_count(fq_count)
    );

    ifetch_pipe #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .imem_en(imem_en_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_pc(out_pc_b), .out_instr(out_instr_b), .fq_count(fq_count_b)
    );

    // Instruction memory returns addr*4+1, one cycle after the request.
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= {{(30-AW){1'b0}}, imem_addr, 2'b00} + 32'd1;
        if (imem_en_b) imem_rdata_b <= {{(30-AW){1'b0}}, imem_addr_b, 2'b00} + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s value=%h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_pcs [3];
        wrap_pcs[0] = 32'hFFFF_FFF8;
        wrap_pcs[1] = 32'hFFFF_FFFC;
        wrap_pcs[2] = 32'h0000_0000;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        tick(); tick(); settle();
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fq_count", 32'(fq_count), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);

        // Reset release with ready held high: 0,4,8,12 from cycle 2.
        tick(); reset = 1'b0; settle();
        check("c0_imem_en", 32'(imem_en), 32'd1);
        check("c0_imem_addr", 32'(imem_addr), 32'd0);
        check("c0_wrap_addr", 32'(imem_addr_b), 32'h1FE);
        for (int k = 1; k <= 5; k++) begin
            tick(); settle();
            if (k == 1) begin
                check("c1_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check($sformatf("rel_valid_c%0d", k), 32'(out_valid), 32'd1);
                check($sformatf("rel_pc_c%0d", k), out_pc, 32'((k-2)*4));
                check($sformatf("rel_instr_c%0d", k), out_instr, 32'((k-2)*4+1));
            end
            if (k >= 2 && k <= 4) begin
                check($sformatf("wrap_pc_c%0d", k), out_pc_b, wrap_pcs[k-2]);
            end
        end

        // Backpressure from cycle 0: queue fills to 4, then drains in order.
        reset = 1'b1; settle();
        tick(); reset = 1'b0; out_ready = 1'b0; settle();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin tick(); settle(); end
            check($sformatf("bp_en_c%0d", k), 32'(imem_en), (k <= 3) ? 32'd1 : 32'd0);
            check($sformatf("bp_cnt_c%0d", k), 32'(fq_count),
                  (k < 2) ? 32'd0 : ((k > 5) ? 32'd4 : 32'(k-1)));
            if (k >= 2) check($sformatf("bp_head_c%0d", k), out_pc, 32'h0);
        end
        for (int k = 8; k <= 13; k++) begin
            tick(); out_ready = 1'b1; settle();
            check($sformatf("drain_valid_c%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("drain_pc_c%0d", k), out_pc, 32'((k-8)*4));
            check($sformatf("drain_instr_c%0d", k), out_instr, 32'((k-8)*4+1));
        end

        // Redirect with two entries queued, then redirect during push+pop,
        // then two back-to-back redirects.
        tick(); reset = 1'b1; out_ready = 1'b1; settle();
        tick(); reset = 1'b0; settle();
        for (int k = 1; k <= 19; k++) begin
            tick();
            redirect_valid = 1'b0;
            if (k == 4) out_ready = 1'b0;
            if (k == 6) out_ready = 1'b1;
            if (k == 5)  begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; end
            if (k == 10) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; end
            if (k == 15) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; end
            if (k == 16) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; end
            settle();
            case (k)
                5: begin
                    check("rd1_cnt_before", 32'(fq_count), 32'd2);
                    check("rd1_no_issue", 32'(imem_en), 32'd0);
                end
                6: begin
                    check("rd1_valid_n1", 32'(out_valid), 32'd0);
                    check("rd1_cnt_n1", 32'(fq_count), 32'd0);
                    check("rd1_en_n1", 32'(imem_en), 32'd1);
                    check("rd1_addr_n1", 32'(imem_addr), 32'h40);
                end
                7: check("rd1_valid_n2", 32'(out_valid), 32'd0);
                8: begin
                    check("rd1_valid_n3", 32'(out_valid), 32'd1);
                    check("rd1_pc_n3", out_pc, 32'h0000_0100);
                    check("rd1_instr_n3", out_instr, 32'h0000_0101);
                end
                9: check("rd1_pc_n4", out_pc, 32'h0000_0104);
                10: begin
                    check("rd2_cnt_before", 32'(fq_count), 32'd1);
                    check("rd2_pc_before", out_pc, 32'h0000_0108);
                end
                11: begin
                    check("rd2_cnt_n1", 32'(fq_count), 32'd0);
                    check("rd2_valid_n1", 32'(out_valid), 32'd0);
                end
                12: check("rd2_valid_n2", 32'(out_valid), 32'd0);
                13: begin
                    check("rd2_pc_n3", out_pc, 32'h0000_0200);
                    check("rd2_instr_n3", out_instr, 32'h0000_0201);
                end
                14: check("rd2_pc_n4", out_pc, 32'h0000_0204);
                17: begin
                    check("rd3_valid_n1", 32'(out_valid), 32'd0);
                    check("rd3_cnt_n1", 32'(fq_count), 32'd0);
                    check("rd3_addr_n1", 32'(imem_addr), 32'h100);
                end
                18: check("rd3_valid_n2", 32'(out_valid), 32'd0);
                19: check("rd3_pc_n3", out_pc, 32'h0000_0400);
                default: ;
            endcase
        end

        // Single-cycle reset with three entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 20 && fq_count != 3'd3; i++) begin
            tick(); settle();
        end
        check("mid_fq3_reached", 32'(fq_count), 32'd3);
        reset = 1'b1; settle();
        tick(); reset = 1'b0; out_ready = 1'b1; settle();
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_cnt", 32'(fq_count), 32'd0);
        check("mid_en", 32'(imem_en), 32'd1);
        check("mid_addr", 32'(imem_addr), 32'd0);
        tick(); tick(); settle();
        check("mid_refetch_valid", 32'(out_valid), 32'd1);
        check("mid_refetch_pc", out_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
